// File: rtl/dmem_bridge_if.sv
// External memory bus between dmem_bridge (master) and the memory (slave).
// A transfer completes on any cycle where bus_req and bus_ready are both high.
interface dmem_bridge_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ready;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// Bridge from the single-cycle core data port to a valid/ready memory bus.
// It posts stores into a small FIFO, forwards them to loads, and stalls the core on read misses.
module dmem_bridge #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              wen,
  input  logic              oen,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  dmem_bridge_if.master     bus
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS, RD_DONE} state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
  logic [DATA_W-1:0] rd_q;

  logic              load, store, full, hit, push, pop;
  logic              start_rd, start_wr, rd_capture;
  logic [DATA_W-1:0] hit_data;
  logic [PTR_W-1:0]  idx;

  assign load  = !cen && wen;
  assign store = !cen && !wen;
  assign full  = (count == CNT_W'(WB_DEPTH));
  assign push  = store && !full;

  // Entries are scanned oldest to newest, so the last match is the newest store to that address.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (wb_addr[idx] == a)) begin
        hit      = 1'b1;
        hit_data = wb_data[idx];
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    rdata = '0;
    if (store) begin
      stall = full;
    end else if (load) begin
      stall = (state != RD_DONE) && !hit;
      if (!oen) begin
        if (state == RD_DONE) rdata = rd_q;
        else if (hit)         rdata = hit_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    start_rd   = 1'b0;
    start_wr   = 1'b0;
    pop        = 1'b0;
    rd_capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (load && !hit) begin
          state_next = RD_BUS;
          start_rd   = 1'b1;
        end else if (count != '0) begin
          state_next = WR_BUS;
          start_wr   = 1'b1;
        end
      end
      WR_BUS: begin
        if (bus.bus_ready) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      RD_BUS: begin
        if (bus.bus_ready) begin
          rd_capture = 1'b1;
          state_next = RD_DONE;
        end
      end
      RD_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      rd_q          <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      state <= state_next;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (rd_capture) rd_q <= bus.bus_rdata;

      if (start_rd) begin
        bus.bus_req  <= 1'b1;
        bus.bus_we   <= 1'b0;
        bus.bus_addr <= a;
      end else if (start_wr) begin
        bus.bus_req   <= 1'b1;
        bus.bus_we    <= 1'b1;
        bus.bus_addr  <= wb_addr[head];
        bus.bus_wdata <= wb_data[head];
      end else if (pop || rd_capture) begin
        bus.bus_req <= 1'b0;
      end
    end
  end

  // NOTE: buffer storage has no reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail] <= a;
      wb_data[tail] <= wdata;
    end
  end

endmodule
